// File: rtl/proc_mem_port_adapter_if.sv
// Signal bundle between a processor port, the port adapter and the memory bus.
// The slave modport is the adapter's view; master is the environment driving it.
interface proc_mem_port_adapter_if;
  logic        proc_val;
  logic        proc_type;
  logic [31:0] proc_addr;
  logic [31:0] proc_wdata;
  logic        proc_wait;
  logic [31:0] proc_rdata;
  logic        mem_req_val;
  logic        mem_req_rdy;
  logic        mem_req_type;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_val;
  logic        mem_resp_rdy;
  logic [31:0] mem_resp_rdata;

  modport slave (
    input  proc_val, proc_type, proc_addr, proc_wdata,
    input  mem_req_rdy, mem_resp_val, mem_resp_rdata,
    output proc_wait, proc_rdata,
    output mem_req_val, mem_req_type, mem_req_addr, mem_req_wdata, mem_resp_rdy
  );

  modport master (
    output proc_val, proc_type, proc_addr, proc_wdata,
    output mem_req_rdy, mem_resp_val, mem_resp_rdata,
    input  proc_wait, proc_rdata,
    input  mem_req_val, mem_req_type, mem_req_addr, mem_req_wdata, mem_resp_rdy
  );
endinterface

// File: rtl/proc_mem_port_adapter.sv
// Converts one stalling processor access into one val/rdy bus transaction,
// with an optional one-entry read buffer that completes repeated reads without a stall.
module proc_mem_port_adapter #(
  parameter bit EN_RDBUF = 1'b1
) (
  input logic                     clk,
  input logic                     rst_n,
  proc_mem_port_adapter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state_q, state_d;
  logic        type_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        buf_v;
  logic [31:0] buf_addr, buf_data;
  logic        hit, latch_req, wait_c;

  assign hit = EN_RDBUF && buf_v && bus.proc_val && !bus.proc_type &&
               (bus.proc_addr == buf_addr);

  assign bus.mem_req_type  = type_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wdata = wdata_q;
  // Forcing wait low under reset keeps the stall output at its reset value
  // even while the processor still holds proc_val.
  assign bus.proc_wait     = rst_n && wait_c;

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d          = state_q;
    latch_req        = 1'b0;
    wait_c           = 1'b0;
    bus.proc_rdata   = '0;
    bus.mem_req_val  = 1'b0;
    bus.mem_resp_rdy = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.proc_val) begin
          if (hit) begin
            bus.proc_rdata = buf_data;
          end else begin
            wait_c    = 1'b1;
            latch_req = 1'b1;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        bus.mem_req_val = 1'b1;
        wait_c          = 1'b1;
        // Once the bus has taken the request it must complete, so acceptance wins.
        if (bus.mem_req_rdy)   state_d = RESP;
        else if (!bus.proc_val) state_d = IDLE;
      end
      RESP: begin
        bus.mem_resp_rdy = 1'b1;
        wait_c           = 1'b1;
        if (bus.mem_resp_val) state_d = DONE;
      end
      DONE: begin
        bus.proc_rdata = type_q ? 32'h0 : rdata_q;
        state_d        = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      type_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      buf_v   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_req) begin
        type_q  <= bus.proc_type;
        addr_q  <= bus.proc_addr;
        wdata_q <= bus.proc_wdata;
      end
      if (state_q == RESP && bus.mem_resp_val) rdata_q <= bus.mem_resp_rdata;
      if (EN_RDBUF && state_q == DONE && !type_q) buf_v <= 1'b1;
    end
  end

  // NOTE: buffer address/data are left unreset; buf_v alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (state_q == DONE) begin
      if (!type_q) begin
        buf_addr <= addr_q;
        buf_data <= rdata_q;
      end else if (buf_v && addr_q == buf_addr) begin
        buf_data <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_proc_mem_port_adapter.sv
// Directed bench for proc_mem_port_adapter: misses, buffer hits, write-through,
// backpressure, abort, asynchronous reset, and a buffer-less instance.
module tb_proc_mem_port_adapter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  proc_mem_port_adapter_if a ();
  proc_mem_port_adapter_if b ();

  proc_mem_port_adapter #(.EN_RDBUF(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(a));
  proc_mem_port_adapter #(.EN_RDBUF(1'b0)) dut_nobuf (.clk(clk), .rst_n(rst_n), .bus(b));

  // sel picks which instance receives proc_val and whose outputs are observed.
  logic        sel = 1'b0;
  logic        p_val = 1'b0, p_type = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0, r_data = '0;
  logic        r_rdy = 1'b0, r_val = 1'b0;

  assign a.proc_val = !sel && p_val;
  assign b.proc_val = sel && p_val;
  assign a.proc_type = p_type;       assign b.proc_type = p_type;
  assign a.proc_addr = p_addr;       assign b.proc_addr = p_addr;
  assign a.proc_wdata = p_wdata;     assign b.proc_wdata = p_wdata;
  assign a.mem_req_rdy = r_rdy;      assign b.mem_req_rdy = r_rdy;
  assign a.mem_resp_val = r_val;     assign b.mem_resp_val = r_val;
  assign a.mem_resp_rdata = r_data;  assign b.mem_resp_rdata = r_data;

  wire        o_wait      = sel ? b.proc_wait     : a.proc_wait;
  wire [31:0] o_rdata     = sel ? b.proc_rdata    : a.proc_rdata;
  wire        o_req_val   = sel ? b.mem_req_val   : a.mem_req_val;
  wire        o_req_type  = sel ? b.mem_req_type  : a.mem_req_type;
  wire [31:0] o_req_addr  = sel ? b.mem_req_addr  : a.mem_req_addr;
  wire [31:0] o_req_wdata = sel ? b.mem_req_wdata : a.mem_req_wdata;
  wire        o_resp_rdy  = sel ? b.mem_resp_rdy  : a.mem_resp_rdy;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One processor access; must be called just after a rising edge.
  // The bus model holds rdy low for req_stall beats and val low for resp_stall cycles.
  task automatic do_access(input string tag, input logic typ, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int req_stall, input int resp_stall,
                           input int exp_stall, input logic [31:0] exp_rdata);
    int cyc = 0;
    int beats = 0;
    int req_n = 0;
    int resp_n = 0;
    bit done = 1'b0;
    p_val = 1'b1; p_type = typ; p_addr = addr; p_wdata = wdata; r_data = rdata;
    r_rdy = 1'b0; r_val = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      r_rdy = 1'b0;
      r_val = 1'b0;
      if (o_req_val) begin
        beats++;
        check({tag, " req_addr"}, o_req_addr, addr);
        check({tag, " req_type"}, 32'(o_req_type), 32'(typ));
        if (typ) check({tag, " req_wdata"}, o_req_wdata, wdata);
        r_rdy = (req_n >= req_stall);
        req_n++;
      end
      if (o_resp_rdy) begin
        r_val = (resp_n >= resp_stall);
        resp_n++;
      end
      if (!o_wait) begin
        done = 1'b1;
        check({tag, " stall"}, 32'(cyc), 32'(exp_stall));
        check({tag, " rdata"}, o_rdata, exp_rdata);
      end else begin
        cyc++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check({tag, " timeout"}, 32'd0, 32'd1);
    check({tag, " req_beats"}, 32'(beats), (exp_stall == 0) ? 32'd0 : 32'(req_stall + 1));
    p_val = 1'b0; r_rdy = 1'b0; r_val = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset wait", 32'(o_wait), 32'd0);
    check("reset rdata", o_rdata, 32'h0);
    check("reset req_val", 32'(o_req_val), 32'd0);
    check("reset resp_rdy", 32'(o_resp_rdy), 32'd0);
    check("reset req_addr", o_req_addr, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_access("rd_miss",    1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 3, 32'hDEADBEEF);
    do_access("rd_hit",     1'b0, 32'h100, 32'h0,        32'hFFFFFFFF, 0, 0, 0, 32'hDEADBEEF);
    do_access("wr_same",    1'b1, 32'h100, 32'h12345678, 32'hBAD0BAD0, 0, 0, 3, 32'h0);
    do_access("rd_wt_hit",  1'b0, 32'h100, 32'h0,        32'hFFFFFFFF, 0, 0, 0, 32'h12345678);
    do_access("wr_other",   1'b1, 32'h104, 32'h55AA55AA, 32'hBAD0BAD0, 0, 0, 3, 32'h0);
    do_access("rd_keep",    1'b0, 32'h100, 32'h0,        32'hFFFFFFFF, 0, 0, 0, 32'h12345678);
    do_access("rd_104",     1'b0, 32'h104, 32'h0,        32'h11112222, 0, 0, 3, 32'h11112222);
    do_access("backpress",  1'b0, 32'h200, 32'h0,        32'hCAFEF00D, 4, 2, 9, 32'hCAFEF00D);

    // Abort: proc_val drops while the request is still unaccepted.
    p_val = 1'b1; p_type = 1'b0; p_addr = 32'h300; r_rdy = 1'b0; r_val = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort req_val", 32'(o_req_val), 32'd1);
    check("abort wait", 32'(o_wait), 32'd1);
    @(posedge clk); #1 p_val = 1'b0;
    @(negedge clk);
    check("abort req_val_drop", 32'(o_req_val), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort idle req_val", 32'(o_req_val), 32'd0);
    check("abort idle wait", 32'(o_wait), 32'd0);
    @(posedge clk); #1;
    do_access("after_abort", 1'b0, 32'h300, 32'h0, 32'h33334444, 0, 0, 3, 32'h33334444);

    // Reset while waiting for a response.
    p_val = 1'b1; p_type = 1'b0; p_addr = 32'h400; r_rdy = 1'b1; r_val = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("resp state rdy", 32'(o_resp_rdy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async wait", 32'(o_wait), 32'd0);
    check("async resp_rdy", 32'(o_resp_rdy), 32'd0);
    check("async req_val", 32'(o_req_val), 32'd0);
    check("async rdata", o_rdata, 32'h0);
    check("async req_addr", o_req_addr, 32'h0);
    p_val = 1'b0; r_rdy = 1'b0; r_val = 1'b1; r_data = 32'h5A5A5A5A;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stale resp_rdy", 32'(o_resp_rdy), 32'd0);
      check("stale rdata", o_rdata, 32'h0);
    end
    r_val = 1'b0;
    @(posedge clk); #1;
    do_access("buf_cleared", 1'b0, 32'h300, 32'h0, 32'h0BADCAFE, 0, 0, 3, 32'h0BADCAFE);

    // Same repeated read on the buffer-less instance stalls both times.
    sel = 1'b1;
    do_access("nobuf rd1", 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 3, 32'hDEADBEEF);
    do_access("nobuf rd2", 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 3, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
